demux_sched4: RTL and testbench
===============================

Name: demux_sched4

Overview:
- Sequential scheduler that steers a single input word stream onto one of four output channels (1-to-4 demux) using valid/ready handshakes.
- Destination comes from an explicit select (addressed mode) or from an internal rotating pointer (round-robin mode).
- Holds one word, times out stuck channels, and counts deliveries and drops.
- Sits between a single producer and four consumers in the same datapath.

Parameters:
- WIDTH, 8, data word width in bits.
- TIMEOUT, 8, cycles a held word waits for its destination's ready before being dropped; 0 disables the timeout (wait forever).
- CNT_W, 8, width of the delivered and dropped counters.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- mode  input  1  0 = addressed (use in_sel), 1 = round-robin (use rr_ptr).
- in_data  input  WIDTH  input word.
- in_sel  input  2  destination channel in addressed mode (0..3).
- in_valid  input  1  producer has a word.
- in_ready  output  1  block can accept a word.
- out_data  output  WIDTH  held word, shared by all four channels.
- out_valid  output  4  one-hot; bit k set means channel k is offered out_data.
- out_ready  input  4  per-channel consumer ready.
- rr_ptr  output  2  next round-robin destination.
- deliv_cnt  output  CNT_W  total words delivered; wraps.
- drop_cnt  output  CNT_W  total words dropped by timeout; wraps.
- drop  output  1  one-cycle pulse when a word is dropped.

Behaviour:
- Reset (asynchronous, immediate, active-high):
  - state=IDLE, out_data=0, out_valid=0, in_ready=1 (IDLE).
  - rr_ptr=0, deliv_cnt=0, drop_cnt=0, drop=0, wait counter=0.
  - Reset during HOLD discards the held word; no count or drop pulse is recorded.
- FSM has two states, IDLE and HOLD.
- IDLE:
  - in_ready=1, out_valid=0.
  - If in_valid=1 at the edge: out_data<=in_data, dest<= mode ? rr_ptr : in_sel, wait<=0, go HOLD.
  - mode and in_sel are sampled only at this acceptance edge; changing them later has no effect on the held word.
- HOLD:
  - in_ready=0; out_valid = one-hot(dest); out_data stable.
  - Delivery: if out_ready[dest]=1 at an edge, deliv_cnt+=1, go IDLE. If the word was accepted in round-robin mode, rr_ptr<=dest+1 mod 4 (3 wraps to 0).
  - out_ready bits of channels other than dest are ignored.
  - Timeout (TIMEOUT>0): if out_ready[dest]=0 and wait==TIMEOUT-1, then drop=1 for the next cycle, drop_cnt+=1, go IDLE. The round-robin pointer advances exactly as for a delivery.
  - Otherwise wait+=1 and stay in HOLD.
  - Delivery and timeout in the same cycle: delivery wins; no drop.
- Timing:
  - Latency: word accepted at edge N gives out_valid high from cycle N+1.
  - Earliest next acceptance is the edge after the exit from HOLD, so peak throughput is 1 word per 2 cycles.
- Counters wrap from 2^CNT_W-1 to 0 with no saturation.
- rr_ptr is unaffected by words accepted in addressed mode.
- drop is low at all times other than the pulse.

Test Plan:
- Addressed delivery, all ready: reset, mode=0, send 0xA5 with in_sel=2 -> out_valid=4'b0100 for 1 cycle, out_data=0xA5, deliv_cnt=1, rr_ptr=0.
- Round-robin sweep: mode=1, out_ready=4'b1111, send 5 words 0x10..0x14 -> out_valid sequence 0001,0010,0100,1000,0001; rr_ptr ends at 1; deliv_cnt=5.
- Backpressure and timeout: TIMEOUT=8, mode=0, in_sel=1, out_ready=0 -> out_valid=0010 held for exactly 8 cycles, then drop pulses once, drop_cnt=1, in_ready=1 again.
  - Repeat with out_ready[1] rising on the 8th HOLD cycle -> delivered, no drop.
- Non-destination ready ignored: dest=3, out_ready=4'b0111 -> no delivery; timeout drop occurs; in round-robin mode rr_ptr advances 3->0.
- Reset mid-HOLD: word held at dest 0 with out_ready=0, assert rst asynchronously between edges -> out_valid=0 immediately, counters=0, in_ready=1; no drop pulse.
- Counter wrap and select change: CNT_W=2, deliver 5 words -> deliv_cnt=1.
  - Change in_sel during HOLD -> destination unchanged.

Source files
------------

// File: rtl/demux_sched4_if.sv
// Handshake bundle between one producer, the demux_sched4 scheduler and its
// four consumers.
//   master : producer/consumer side (drives mode, in_*, out_ready)
//   slave  : scheduler side (drives in_ready, out_*, rr_ptr, counters, drop)
interface demux_sched4_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 8
);
    logic             mode;
    logic [WIDTH-1:0] in_data;
    logic [1:0]       in_sel;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic [3:0]       out_valid;
    logic [3:0]       out_ready;
    logic [1:0]       rr_ptr;
    logic [CNT_W-1:0] deliv_cnt;
    logic [CNT_W-1:0] drop_cnt;
    logic             drop;

    modport master (
        output mode, in_data, in_sel, in_valid, out_ready,
        input  in_ready, out_data, out_valid, rr_ptr, deliv_cnt, drop_cnt, drop
    );

    modport slave (
        input  mode, in_data, in_sel, in_valid, out_ready,
        output in_ready, out_data, out_valid, rr_ptr, deliv_cnt, drop_cnt, drop
    );
endinterface

// File: rtl/demux_sched4.sv
// 1-to-4 demux scheduler: accepts one word, offers it to a single channel
// chosen by in_sel (addressed) or the round-robin pointer, and drops it if
// the channel stays not-ready for TIMEOUT cycles (0 = never drop).
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : demux_sched4_if.slave (producer handshake, four consumer
//          channels, rr_ptr, delivered/dropped counters, drop pulse)
module demux_sched4 #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned TIMEOUT = 8,
    parameter int unsigned CNT_W   = 8
) (
    input  logic           clk,
    input  logic           rst,
    demux_sched4_if.slave  bus
);

    localparam int unsigned WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST =
        (TIMEOUT == 0) ? '0 : WAIT_W'(TIMEOUT - 1);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t            state;
    logic [WIDTH-1:0]  data_q;
    logic [1:0]        dest_q;
    logic              rr_acc_q;
    logic [WAIT_W-1:0] wait_q;
    logic [1:0]        rr_q;
    logic [CNT_W-1:0]  deliv_q;
    logic [CNT_W-1:0]  drop_cnt_q;
    logic              drop_q;
    logic              in_ready_q;
    logic [3:0]        out_valid_q;

    logic [1:0] sel_dest;
    logic       dest_ready;
    logic       timeout_hit;

    // Destination chosen at acceptance; readiness of the held word's channel.
    assign sel_dest    = bus.mode ? rr_q : bus.in_sel;
    assign dest_ready  = bus.out_ready[dest_q];
    assign timeout_hit = (TIMEOUT != 0) && (wait_q == WAIT_LAST);

    // Scheduler FSM with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            data_q      <= '0;
            dest_q      <= 2'd0;
            rr_acc_q    <= 1'b0;
            wait_q      <= '0;
            rr_q        <= 2'd0;
            deliv_q     <= '0;
            drop_cnt_q  <= '0;
            drop_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 4'b0000;
        end else begin
            drop_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        data_q      <= bus.in_data;
                        dest_q      <= sel_dest;
                        rr_acc_q    <= bus.mode;
                        wait_q      <= '0;
                        in_ready_q  <= 1'b0;
                        out_valid_q <= 4'b0001 << sel_dest;
                        state       <= HOLD;
                    end
                end
                HOLD: begin
                    // Delivery takes priority over a coincident timeout.
                    if (dest_ready || timeout_hit) begin
                        if (dest_ready) begin
                            deliv_q <= deliv_q + CNT_W'(1);
                        end else begin
                            drop_cnt_q <= drop_cnt_q + CNT_W'(1);
                            drop_q     <= 1'b1;
                        end
                        // Pointer advances only for words taken in round-robin mode.
                        if (rr_acc_q) begin
                            rr_q <= dest_q + 2'd1;
                        end
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 4'b0000;
                        state       <= IDLE;
                    end else begin
                        wait_q <= wait_q + WAIT_W'(1);
                    end
                end
                default: begin
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 4'b0000;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_data  = data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.rr_ptr    = rr_q;
    assign bus.deliv_cnt = deliv_q;
    assign bus.drop_cnt  = drop_cnt_q;
    assign bus.drop      = drop_q;

endmodule

// File: tb/tb_demux_sched4.sv
// Self-checking bench for demux_sched4: directed scenarios followed by random
// traffic, all compared against a transaction-level reference model. A second
// instance with 2-bit counters shares the stimulus to exercise counter wrap.
module tb_demux_sched4;

    localparam int unsigned TMO = 8;

    logic clk;
    logic rst;

    demux_sched4_if #(.WIDTH(8), .CNT_W(8)) ifa ();
    demux_sched4_if #(.WIDTH(8), .CNT_W(2)) ifb ();

    assign ifb.mode      = ifa.mode;
    assign ifb.in_data   = ifa.in_data;
    assign ifb.in_sel    = ifa.in_sel;
    assign ifb.in_valid  = ifa.in_valid;
    assign ifb.out_ready = ifa.out_ready;

    demux_sched4 #(.WIDTH(8), .TIMEOUT(TMO), .CNT_W(8)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa.slave)
    );

    demux_sched4 #(.WIDTH(8), .TIMEOUT(TMO), .CNT_W(2)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: one held transaction and running totals.
    bit         m_busy;
    int         m_dest;
    int         m_age;
    bit         m_rr_acc;
    logic [7:0] m_data;
    int         m_rr;
    int         m_deliv;
    int         m_drops;
    bit         m_drop;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_dest = 0; m_age = 0; m_rr_acc = 0; m_data = 8'h00;
        m_rr = 0; m_deliv = 0; m_drops = 0; m_drop = 0;
    endtask

    task automatic model_release();
        m_busy = 0;
        if (m_rr_acc) m_rr = (m_dest + 1) % 4;
    endtask

    // Advance the model by one clock edge using the inputs presented to it.
    task automatic model_step();
        m_drop = 0;
        if (!m_busy) begin
            if (ifa.in_valid) begin
                m_busy   = 1;
                m_data   = ifa.in_data;
                m_dest   = ifa.mode ? m_rr : int'(ifa.in_sel);
                m_rr_acc = ifa.mode;
                m_age    = 0;
            end
        end else begin
            m_age++;
            if (ifa.out_ready[m_dest]) begin
                m_deliv++;
                model_release();
            end else if (TMO > 0 && m_age >= int'(TMO)) begin
                m_drops++;
                m_drop = 1;
                model_release();
            end
        end
    endtask

    task automatic check_outputs();
        logic [3:0] ov;
        ov = m_busy ? (4'b0001 << m_dest) : 4'b0000;
        check("in_ready",  32'(ifa.in_ready),  32'(!m_busy));
        check("out_valid", 32'(ifa.out_valid), 32'(ov));
        if (m_busy) check("out_data", 32'(ifa.out_data), 32'(m_data));
        check("rr_ptr",    32'(ifa.rr_ptr),    32'(m_rr));
        check("deliv_cnt", 32'(ifa.deliv_cnt), 32'(m_deliv % 256));
        check("drop_cnt",  32'(ifa.drop_cnt),  32'(m_drops % 256));
        check("drop",      32'(ifa.drop),      32'(m_drop));
        check("b_out_valid", 32'(ifb.out_valid), 32'(ov));
        check("b_deliv_cnt", 32'(ifb.deliv_cnt), 32'(m_deliv % 4));
        check("b_drop_cnt",  32'(ifb.drop_cnt),  32'(m_drops % 4));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        ifa.in_valid = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        check_outputs();
        check("rst_out_data", 32'(ifa.out_data), 32'h0);
    endtask

    // Present one word for a single acceptance edge.
    task automatic send(input logic [7:0] d);
        ifa.in_data  = d;
        ifa.in_valid = 1'b1;
        tick();
        ifa.in_valid = 1'b0;
    endtask

    initial begin
        logic [3:0] rr_seq [5];
        int held;

        rst = 1'b1;
        ifa.mode = 1'b0; ifa.in_data = 8'h00; ifa.in_sel = 2'd0;
        ifa.in_valid = 1'b0; ifa.out_ready = 4'b0000;
        model_reset();

        // Addressed delivery, all ready.
        do_reset();
        ifa.mode = 1'b0; ifa.in_sel = 2'd2; ifa.out_ready = 4'b1111;
        send(8'hA5);
        check("addr_valid", 32'(ifa.out_valid), 32'h4);
        check("addr_data",  32'(ifa.out_data),  32'hA5);
        tick();
        check("addr_deliv", 32'(ifa.deliv_cnt), 32'd1);
        check("addr_rr",    32'(ifa.rr_ptr),    32'd0);

        // Round-robin sweep.
        do_reset();
        rr_seq[0] = 4'b0001; rr_seq[1] = 4'b0010; rr_seq[2] = 4'b0100;
        rr_seq[3] = 4'b1000; rr_seq[4] = 4'b0001;
        ifa.mode = 1'b1; ifa.out_ready = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            send(8'(8'h10 + i));
            check("rr_valid", 32'(ifa.out_valid), 32'(rr_seq[i]));
            tick();
        end
        check("rr_end_ptr", 32'(ifa.rr_ptr),    32'd1);
        check("rr_deliv",   32'(ifa.deliv_cnt), 32'd5);

        // Backpressure and timeout.
        do_reset();
        ifa.mode = 1'b0; ifa.in_sel = 2'd1; ifa.out_ready = 4'b0000;
        send(8'h3C);
        held = 0;
        for (int i = 0; i < 20; i++) begin
            if (ifa.out_valid != 4'b0010) break;
            held++;
            tick();
        end
        check("tmo_held", 32'(held), 32'(TMO));
        check("tmo_drop_pulse", 32'(ifa.drop), 32'd1);
        check("tmo_drop_cnt", 32'(ifa.drop_cnt), 32'd1);
        check("tmo_in_ready", 32'(ifa.in_ready), 32'd1);
        tick();

        // Ready arrives on the last allowed HOLD cycle: delivered, no drop.
        send(8'h5A);
        repeat (TMO - 1) tick();
        ifa.out_ready = 4'b0010;
        tick();
        check("late_deliv", 32'(ifa.deliv_cnt), 32'd1);
        check("late_drops", 32'(ifa.drop_cnt),  32'd1);
        check("late_drop",  32'(ifa.drop),      32'd0);

        // Non-destination ready ignored; pointer wraps 3 -> 0 on drop.
        do_reset();
        ifa.mode = 1'b1; ifa.out_ready = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            send(8'(8'h20 + i));
            tick();
        end
        check("nd_rr3", 32'(ifa.rr_ptr), 32'd3);
        ifa.out_ready = 4'b0111;
        send(8'h77);
        repeat (TMO) tick();
        check("nd_drops", 32'(ifa.drop_cnt),  32'd1);
        check("nd_deliv", 32'(ifa.deliv_cnt), 32'd3);
        check("nd_rr0",   32'(ifa.rr_ptr),    32'd0);

        // Reset between edges while holding a word.
        do_reset();
        ifa.mode = 1'b0; ifa.in_sel = 2'd0; ifa.out_ready = 4'b0001;
        send(8'h11);
        tick();
        ifa.out_ready = 4'b0000;
        send(8'h22);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(ifa.out_valid), 32'h0);
        check("mid_rst_ready", 32'(ifa.in_ready),  32'd1);
        check("mid_rst_deliv", 32'(ifa.deliv_cnt), 32'd0);
        check("mid_rst_drop",  32'(ifa.drop),      32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        check_outputs();
        repeat (TMO + 2) tick();

        // Counter wrap on the 2-bit instance and select change during HOLD.
        do_reset();
        ifa.mode = 1'b0; ifa.in_sel = 2'd3; ifa.out_ready = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            send(8'(8'h40 + i));
            tick();
        end
        check("wrap_b_deliv", 32'(ifb.deliv_cnt), 32'd1);
        check("wrap_a_deliv", 32'(ifa.deliv_cnt), 32'd5);
        ifa.out_ready = 4'b0000; ifa.in_sel = 2'd2;
        send(8'h99);
        ifa.in_sel = 2'd3; ifa.mode = 1'b1;
        tick();
        check("sel_change_valid", 32'(ifa.out_valid), 32'h4);
        ifa.out_ready = 4'b1000;
        tick();
        ifa.out_ready = 4'b0100;
        tick();
        check("sel_change_deliv", 32'(ifa.deliv_cnt), 32'd6);
        check("sel_change_rr",    32'(ifa.rr_ptr),    32'd0);

        // Random traffic.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            ifa.in_valid  = 1'($urandom_range(0, 1));
            ifa.mode      = 1'($urandom_range(0, 1));
            ifa.in_sel    = 2'($urandom_range(0, 3));
            ifa.in_data   = 8'($urandom);
            for (int k = 0; k < 4; k++)
                ifa.out_ready[k] = ($urandom_range(0, 3) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
